// File: rtl/matrix_operand_loader.sv
// Streams DIM*DIM elements of m1 then m2 over valid/ready, then presents both packed operands until mult_ack.
// Define MATRIX_LOADER_TRANSPOSE_M2_EN to treat the m2 stream as column-major and store its transpose row-major.
module matrix_operand_loader #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      abort,
  input  logic                      mult_ack,
  output logic [DIM*DIM*ELEM_W-1:0] m1,
  output logic [DIM*DIM*ELEM_W-1:0] m2,
  output logic                      mult_enable,
  output logic [$clog2(2*DIM*DIM)-1:0] load_count
);

  localparam int N     = DIM * DIM;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(2 * N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    LOAD_M1,
    LOAD_M2,
    PRESENT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  m2_idx;
  logic              last;
  logic              accept;
  logic              restart;

  // Both handshake outputs decode the state register only, so in_valid never reaches in_ready.
  assign in_ready    = (state != PRESENT);
  assign mult_enable = (state == PRESENT);
  assign last        = (idx == IDX_LAST);

`ifdef MATRIX_LOADER_TRANSPOSE_M2_EN
  assign m2_idx = IDX_W'((int'(idx) % DIM) * DIM + int'(idx) / DIM);
`else
  assign m2_idx = idx;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    restart   = 1'b0;
    case (state)
      LOAD_M1: begin
        if (abort) begin
          restart = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (last) state_nxt = LOAD_M2;
        end
      end
      LOAD_M2: begin
        if (abort) begin
          restart = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (last) state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (abort || mult_ack) restart = 1'b1;
      end
      default: restart = 1'b1;
    endcase
    if (restart) state_nxt = LOAD_M1;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values of idx and state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD_M1;
      idx        <= '0;
      load_count <= '0;
      // NOTE: the operand registers are cleared on reset because m1/m2 are observable outputs with defined reset values.
      m1         <= '0;
      m2         <= '0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        idx        <= '0;
        load_count <= '0;
      end else if (accept) begin
        idx        <= last ? '0 : idx + 1'b1;
        load_count <= (load_count == CNT_MAX) ? load_count : load_count + 1'b1;
      end
      if (accept && state == LOAD_M1) m1[idx * ELEM_W +: ELEM_W] <= in_data;
      if (accept && state == LOAD_M2) m2[m2_idx * ELEM_W +: ELEM_W] <= in_data;
    end
  end

endmodule
